// File: rtl/blake2_input_controller.sv
// Buffers streamed words into BLAKE2b blocks and sequences init/next/final through the core.
// Latency: init 1 cycle after request; each block 1 + core latency + 1 cycles; writes are dropped (not stalled) when full or hashing.
module blake2_input_controller #(
   parameter int BUS_WIDTH   = 64,
   parameter int BLOCK_WIDTH = 1024,
   parameter int MAX_BLOCKS  = 4,
   parameter int DATA_LENGTH = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   valid_in,
   input  logic                   new_hash_request,
   input  logic [BUS_WIDTH-1:0]   din,
   output logic                   init,
   output logic                   next,
   output logic                   final_block,
   output logic [BLOCK_WIDTH-1:0] block,
   output logic [DATA_LENGTH-1:0] data_length,
   input  logic                   hash_ready,
   input  logic                   digest_valid,
   output logic                   hash_started,
   output logic                   cont_buf_empty,
   output logic                   cont_buf_full
);
   localparam int WPB   = BLOCK_WIDTH / BUS_WIDTH;
   localparam int DEPTH = MAX_BLOCKS * WPB;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = $clog2(MAX_BLOCKS + 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] INIT      = 3'd1;
   localparam logic [2:0] WAIT_INIT = 3'd2;
   localparam logic [2:0] NEXT      = 3'd3;
   localparam logic [2:0] WAIT_BLK  = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   logic [2:0]             state;
   logic [CW-1:0]          count;
   logic [BW-1:0]          blk;
   logic [BW-1:0]          nblk;
   logic [BW-1:0]          blk_nxt;
   logic                   settle;
   logic [BUS_WIDTH-1:0]   mem [DEPTH];
   logic [BLOCK_WIDTH-1:0] block_nxt;
   logic [DATA_LENGTH-1:0] len_nxt;
   int                     words_nxt;
   logic                   wr_en;
   logic                   unused_digest_valid;

   assign unused_digest_valid = digest_valid;
   assign init           = (state == INIT);
   assign next           = (state == NEXT);
   assign hash_started   = (state != IDLE);
   assign cont_buf_empty = (count == '0);
   assign cont_buf_full  = (count == CW'(DEPTH));
   assign wr_en          = (state == IDLE) && valid_in && !cont_buf_full;

   // An empty buffer still hashes one all-zero block.
   always_comb begin
      nblk = BW'(1);
      if (count != '0) nblk = BW'((int'(count) + WPB - 1) / WPB);
   end

   assign blk_nxt = (state == WAIT_INIT) ? '0 : blk + BW'(1);

   // Words past the fill level are masked so stale data from an earlier message never leaks.
   always_comb begin
      block_nxt = '0;
      for (int j = 0; j < WPB; j++) begin
         if (int'(blk_nxt) * WPB + j < int'(count))
            block_nxt[j*BUS_WIDTH +: BUS_WIDTH] = mem[AW'(int'(blk_nxt) * WPB + j)];
      end
   end

   always_comb begin
      words_nxt = (int'(blk_nxt) + 1) * WPB;
      if (words_nxt > int'(count)) words_nxt = int'(count);
      len_nxt = DATA_LENGTH'(words_nxt * (BUS_WIDTH / 8));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[AW'(count)] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         blk         <= '0;
         settle      <= 1'b0;
         block       <= '0;
         data_length <= '0;
         final_block <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en) count <= count + CW'(1);
               if (new_hash_request && hash_ready) state <= INIT;
            end
            INIT: begin
               state  <= WAIT_INIT;
               settle <= 1'b1;
            end
            // First wait cycle skips hash_ready: the core has not yet reacted to the pulse.
            WAIT_INIT, WAIT_BLK: begin
               if (settle) begin
                  settle <= 1'b0;
               end else if (hash_ready) begin
                  if (state == WAIT_BLK && blk == nblk - BW'(1)) begin
                     state <= DONE;
                  end else begin
                     state       <= NEXT;
                     blk         <= blk_nxt;
                     block       <= block_nxt;
                     data_length <= len_nxt;
                     final_block <= (blk_nxt == nblk - BW'(1));
                  end
               end
            end
            NEXT: begin
               state  <= WAIT_BLK;
               settle <= 1'b1;
            end
            DONE: begin
               count       <= '0;
               blk         <= '0;
               final_block <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_blake2_input_controller.sv
// Bench for blake2_input_controller with a behavioural core model and a queue-based message model.
module tb_blake2_input_controller;
   localparam int WPB   = 16;
   localparam int DEPTH = 64;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           valid_in;
   logic           new_hash_request;
   logic [63:0]    din;
   logic           init;
   logic           next;
   logic           final_block;
   logic [1023:0]  block;
   logic [63:0]    data_length;
   logic           hash_ready;
   logic           digest_valid;
   logic           hash_started;
   logic           cont_buf_empty;
   logic           cont_buf_full;

   int checks = 0;
   int failures = 0;

   logic [63:0]   exp_q[$];
   logic [1023:0] cap_blk[$];
   logic [63:0]   cap_len[$];
   logic          cap_fin[$];
   int            init_cnt = 0;
   int            dig_cnt = 0;

   int   busy;
   logic pend_final;

   blake2_input_controller dut (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .new_hash_request(new_hash_request),
      .din(din), .init(init), .next(next), .final_block(final_block), .block(block),
      .data_length(data_length), .hash_ready(hash_ready), .digest_valid(digest_valid),
      .hash_started(hash_started), .cont_buf_empty(cont_buf_empty), .cont_buf_full(cont_buf_full)
   );

   always #5 clk = ~clk;

   // Core model: drops ready for a random 1..4 cycles after each pulse, digest on the final block.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hash_ready   <= 1'b1;
         digest_valid <= 1'b0;
         busy         <= 0;
         pend_final   <= 1'b0;
      end else begin
         digest_valid <= 1'b0;
         if (init || next) begin
            hash_ready <= 1'b0;
            busy       <= int'($urandom_range(1, 4));
            pend_final <= next && final_block;
         end else if (!hash_ready) begin
            if (busy <= 1) begin
               hash_ready   <= 1'b1;
               digest_valid <= pend_final;
            end else begin
               busy <= busy - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (init) init_cnt++;
      if (digest_valid) dig_cnt++;
      if (next) begin
         cap_blk.push_back(block);
         cap_len.push_back(data_length);
         cap_fin.push_back(final_block);
      end
   end

   function automatic int exp_nblk();
      return (exp_q.size() == 0) ? 1 : (exp_q.size() + WPB - 1) / WPB;
   endfunction

   function automatic logic [1023:0] exp_block(input int b);
      logic [1023:0] r;
      r = '0;
      for (int j = 0; j < WPB; j++)
         if (b * WPB + j < exp_q.size()) r[j*64 +: 64] = exp_q[b*WPB + j];
      return r;
   endfunction

   function automatic logic [63:0] exp_len(input int b);
      int w;
      w = (b + 1) * WPB;
      if (w > exp_q.size()) w = exp_q.size();
      return 64'(w * 8);
   endfunction

   // Entry and exit at posedge+1.
   task automatic write_word(input logic [63:0] w);
      valid_in = 1'b1;
      din = w;
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
   endtask

   task automatic wait_caps(input int target, input string name);
      bit ok;
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (cap_blk.size() >= target) ok = 1;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL %s next_wait got=%0d need=%0d", name, cap_blk.size(), target); end
   endtask

   task automatic do_hash(input string name, input bit midhash);
      int  base_cap, base_init, base_dig, nb;
      bit  ok;
      base_cap = cap_blk.size();
      base_init = init_cnt;
      base_dig = dig_cnt;
      new_hash_request = 1'b1;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (hash_started === 1'b1) ok = 1;
      end
      checks++;
      if (!ok) begin
         failures++; $display("FAIL %s start got=%b need=1", name, hash_started);
         new_hash_request = 1'b0; @(posedge clk); #1; return;
      end
      checks++;
      if (init !== 1'b1) begin failures++; $display("FAIL %s init_latency got=%b need=1", name, init); end
      new_hash_request = 1'b0;
      if (midhash) begin
         wait_caps(base_cap + 1, name);
         valid_in = 1'b1; new_hash_request = 1'b1; din = {$urandom, $urandom};
         wait_caps(base_cap + 2, name);
         valid_in = 1'b0; new_hash_request = 1'b0;
      end
      ok = 0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         if (hash_started === 1'b0) ok = 1;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL %s done got=%b need=0", name, hash_started); end
      nb = exp_nblk();
      checks++;
      if (cap_blk.size() - base_cap != nb) begin
         failures++; $display("FAIL %s nblocks got=%0d need=%0d", name, cap_blk.size() - base_cap, nb);
      end else begin
         for (int b = 0; b < nb; b++) begin
            checks++;
            if (cap_blk[base_cap+b] !== exp_block(b)) begin failures++;
               $display("FAIL %s blk%0d block got=%h need=%h", name, b, cap_blk[base_cap+b], exp_block(b)); end
            checks++;
            if (cap_len[base_cap+b] !== exp_len(b)) begin failures++;
               $display("FAIL %s blk%0d data_length got=%0d need=%0d", name, b, cap_len[base_cap+b], exp_len(b)); end
            checks++;
            if (cap_fin[base_cap+b] !== (b == nb - 1)) begin failures++;
               $display("FAIL %s blk%0d final_block got=%b need=%b", name, b, cap_fin[base_cap+b], b == nb - 1); end
         end
      end
      checks++;
      if (init_cnt - base_init != 1) begin failures++; $display("FAIL %s init_count got=%0d need=1", name, init_cnt - base_init); end
      checks++;
      if (dig_cnt - base_dig != 1) begin failures++; $display("FAIL %s digest_count got=%0d need=1", name, dig_cnt - base_dig); end
      checks++;
      if (cont_buf_empty !== 1'b1) begin failures++; $display("FAIL %s empty_after got=%b need=1", name, cont_buf_empty); end
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (init !== 1'b0) begin failures++; $display("FAIL reset init got=%b need=0", init); end
      checks++; if (next !== 1'b0) begin failures++; $display("FAIL reset next got=%b need=0", next); end
      checks++; if (final_block !== 1'b0) begin failures++; $display("FAIL reset final_block got=%b need=0", final_block); end
      checks++; if (hash_started !== 1'b0) begin failures++; $display("FAIL reset hash_started got=%b need=0", hash_started); end
      checks++; if (cont_buf_empty !== 1'b1) begin failures++; $display("FAIL reset empty got=%b need=1", cont_buf_empty); end
      checks++; if (cont_buf_full !== 1'b0) begin failures++; $display("FAIL reset full got=%b need=0", cont_buf_full); end
      checks++; if (block !== '0) begin failures++; $display("FAIL reset block got=%h need=0", block); end
      checks++; if (data_length !== 64'd0) begin failures++; $display("FAIL reset data_length got=%0d need=0", data_length); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill60();
      int base;
      logic [1023:0] b0, b3;
      for (int i = 1; i <= 60; i++) write_word(64'(i));
      checks++; if (cont_buf_empty !== 1'b0) begin failures++; $display("FAIL fill60 empty got=%b need=0", cont_buf_empty); end
      base = cap_blk.size();
      do_hash("fill60", 1'b0);
      if (cap_blk.size() >= base + 4) begin
         b0 = cap_blk[base];
         b3 = cap_blk[base+3];
         checks++; if (b0[63:0] !== 64'd1) begin failures++; $display("FAIL fill60 b0_lsw got=%0d need=1", b0[63:0]); end
         checks++; if (b0[1023:960] !== 64'd16) begin failures++; $display("FAIL fill60 b0_msw got=%0d need=16", b0[1023:960]); end
         checks++; if (b3[1023:768] !== '0) begin failures++; $display("FAIL fill60 b3_pad got=%h need=0", b3[1023:768]); end
         checks++; if (cap_len[base+3] !== 64'd480) begin failures++; $display("FAIL fill60 len3 got=%0d need=480", cap_len[base+3]); end
      end else begin
         checks++; failures++; $display("FAIL fill60 pulses got=%0d need=4", cap_blk.size() - base);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 70; i++) begin
         write_word({$urandom, $urandom});
         if (i == 63 || i == 64 || i == 70) begin
            checks++;
            if (cont_buf_full !== (i >= 64)) begin failures++;
               $display("FAIL overflow full_at_%0d got=%b need=%b", i, cont_buf_full, i >= 64); end
         end
      end
      do_hash("overflow", 1'b0);
   endtask

   task automatic test_midhash();
      int base_init;
      for (int i = 0; i < 40; i++) write_word({$urandom, $urandom});
      base_init = init_cnt;
      do_hash("midhash", 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (hash_started !== 1'b0) begin failures++; $display("FAIL midhash restart got=%b need=0", hash_started); end
      checks++; if (init_cnt - base_init != 1) begin failures++; $display("FAIL midhash extra_init got=%0d need=1", init_cnt - base_init); end
   endtask

   task automatic test_random();
      int n;
      for (int k = 0; k < 4; k++) begin
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) write_word({$urandom, $urandom});
         do_hash("random", 1'b0);
      end
   endtask

   task automatic test_reset_midhash();
      int base;
      for (int i = 0; i < 10; i++) write_word({$urandom, $urandom});
      base = cap_blk.size();
      new_hash_request = 1'b1;
      @(posedge clk); #1;
      new_hash_request = 1'b0;
      wait_caps(base + 1, "rst_mid");
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      checks++; if (hash_started !== 1'b0) begin failures++; $display("FAIL rst_mid hash_started got=%b need=0", hash_started); end
      checks++; if (final_block !== 1'b0) begin failures++; $display("FAIL rst_mid final_block got=%b need=0", final_block); end
      checks++; if (next !== 1'b0) begin failures++; $display("FAIL rst_mid next got=%b need=0", next); end
      checks++; if (block !== '0) begin failures++; $display("FAIL rst_mid block got=%h need=0", block); end
      checks++; if (data_length !== 64'd0) begin failures++; $display("FAIL rst_mid data_length got=%0d need=0", data_length); end
      checks++; if (cont_buf_empty !== 1'b1) begin failures++; $display("FAIL rst_mid empty got=%b need=1", cont_buf_empty); end
      exp_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (hash_started !== 1'b0) begin failures++; $display("FAIL rst_mid idle_after got=%b need=0", hash_started); end
      for (int i = 0; i < 5; i++) write_word({$urandom, $urandom});
      do_hash("post_reset", 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      valid_in = 1'b0;
      new_hash_request = 1'b0;
      din = '0;
      test_reset();
      test_fill60();
      test_overflow();
      do_hash("empty", 1'b0);
      test_midhash();
      test_random();
      test_reset_midhash();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
